// File: rtl/video_fill_dma_pkg.sv
// Shared types and constants for the rectangle-fill DMA engine.
// Address width matches the SDRAM arbiter's 16-bit word address space.
package video_fill_dma_pkg;

    localparam int SDRAM_ADDR_X16_BITS = 24;

    typedef logic [SDRAM_ADDR_X16_BITS-1:0] sdram_addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        DONE = 2'd3
    } fill_state_t;

    // Word-address addition; wraps silently modulo the SDRAM address space.
    function automatic sdram_addr_t addr_add(input sdram_addr_t a, input sdram_addr_t b);
        return a + b;
    endfunction

endpackage

// File: rtl/fill_addr_gen.sv
// Rectangle address walker: x/y counters, row base and current word address.
// Loaded on start, advanced one word per step strobe; last flags the final word.
module fill_addr_gen
    import video_fill_dma_pkg::*;
#(
    parameter int DIM_BITS   = 11,
    parameter int PITCH_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  sdram_addr_t           base,
    input  logic [DIM_BITS-1:0]   width,
    input  logic [DIM_BITS-1:0]   height,
    input  logic [PITCH_BITS-1:0] pitch,
    output sdram_addr_t           addr,
    output logic                  last
);

    logic [DIM_BITS-1:0]   x_r;
    logic [DIM_BITS-1:0]   y_r;
    logic [DIM_BITS-1:0]   width_r;
    logic [DIM_BITS-1:0]   height_r;
    logic [PITCH_BITS-1:0] pitch_r;
    sdram_addr_t           row_base_r;
    sdram_addr_t           addr_r;
    logic                  x_more_s;
    logic                  y_more_s;
    sdram_addr_t           next_row_s;

    assign addr = addr_r;

    // Compare in DIM_BITS+1 so x+1 cannot overflow at the maximum width.
    always_comb begin
        x_more_s   = ({1'b0, x_r} + (DIM_BITS+1)'(1)) < {1'b0, width_r};
        y_more_s   = ({1'b0, y_r} + (DIM_BITS+1)'(1)) < {1'b0, height_r};
        next_row_s = addr_add(row_base_r, sdram_addr_t'(pitch_r));
        last       = !x_more_s && !y_more_s;
    end

    // Counter and address registers; a new line restarts at the previous row base plus pitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r        <= {DIM_BITS{1'b0}};
            y_r        <= {DIM_BITS{1'b0}};
            width_r    <= {DIM_BITS{1'b0}};
            height_r   <= {DIM_BITS{1'b0}};
            pitch_r    <= {PITCH_BITS{1'b0}};
            row_base_r <= {SDRAM_ADDR_X16_BITS{1'b0}};
            addr_r     <= {SDRAM_ADDR_X16_BITS{1'b0}};
        end else if (load) begin
            x_r        <= {DIM_BITS{1'b0}};
            y_r        <= {DIM_BITS{1'b0}};
            width_r    <= width;
            height_r   <= height;
            pitch_r    <= pitch;
            row_base_r <= base;
            addr_r     <= base;
        end else if (step) begin
            if (x_more_s) begin
                x_r    <= x_r + DIM_BITS'(1);
                addr_r <= addr_add(addr_r, sdram_addr_t'(1));
            end else if (y_more_s) begin
                x_r        <= {DIM_BITS{1'b0}};
                y_r        <= y_r + DIM_BITS'(1);
                row_base_r <= next_row_s;
                addr_r     <= next_row_s;
            end else begin
                x_r <= x_r;
            end
        end else begin
            x_r <= x_r;
        end
    end

endmodule

// File: rtl/video_fill_dma.sv
// Rectangle-fill DMA: writes a constant 16-bit word over a framebuffer region
// through a single-outstanding SDRAM arbiter write port.
module video_fill_dma
    import video_fill_dma_pkg::*;
#(
    parameter int DIM_BITS   = 11,
    parameter int PITCH_BITS = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic                           abort_i,
    input  logic [SDRAM_ADDR_X16_BITS-1:0] base_addr_x16_i,
    input  logic [DIM_BITS-1:0]            width_i,
    input  logic [DIM_BITS-1:0]            height_i,
    input  logic [PITCH_BITS-1:0]          pitch_i,
    input  logic [15:0]                    fill_i,
    input  logic [1:0]                     wmask_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           sdram_wr,
    output logic [SDRAM_ADDR_X16_BITS-1:0] sdram_addr_x16,
    output logic [15:0]                    sdram_wdata,
    output logic [1:0]                     sdram_wmask,
    input  logic                           sdram_rdy,
    input  logic                           sdram_ack
);

    fill_state_t state_r;
    logic        abort_pend_r;
    logic        accept_s;
    logic        empty_s;
    logic        load_s;
    logic        step_s;
    logic        last_s;

    // Start acceptance and address-walker strobes.
    always_comb begin
        accept_s = start_i && !abort_i && (state_r == IDLE);
        empty_s  = (width_i == {DIM_BITS{1'b0}}) || (height_i == {DIM_BITS{1'b0}});
        load_s   = accept_s && !empty_s;
        step_s   = (state_r == ACK) && sdram_ack && !last_s && !abort_pend_r && !abort_i;
    end

    fill_addr_gen #(
        .DIM_BITS   (DIM_BITS),
        .PITCH_BITS (PITCH_BITS)
    ) u_addr_gen (
        .clk    (clk_i),
        .rst    (rst_i),
        .load   (load_s),
        .step   (step_s),
        .base   (base_addr_x16_i),
        .width  (width_i),
        .height (height_i),
        .pitch  (pitch_i),
        .addr   (sdram_addr_x16),
        .last   (last_s)
    );

    // Control FSM; an abort after acceptance is deferred until the in-flight write is acked.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            sdram_wr     <= 1'b0;
            sdram_wdata  <= 16'h0000;
            sdram_wmask  <= 2'b00;
            abort_pend_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_o <= 1'b0;
                    if (accept_s) begin
                        busy_o       <= 1'b1;
                        sdram_wdata  <= fill_i;
                        sdram_wmask  <= wmask_i;
                        abort_pend_r <= 1'b0;
                        if (empty_s) begin
                            state_r <= DONE;
                        end else begin
                            state_r  <= REQ;
                            sdram_wr <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (sdram_rdy) begin
                        sdram_wr     <= 1'b0;
                        state_r      <= ACK;
                        abort_pend_r <= abort_i;
                    end else if (abort_i) begin
                        sdram_wr <= 1'b0;
                        busy_o   <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                ACK: begin
                    if (sdram_ack) begin
                        abort_pend_r <= 1'b0;
                        if (abort_pend_r || abort_i) begin
                            busy_o  <= 1'b0;
                            state_r <= IDLE;
                        end else if (last_s) begin
                            done_o  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            sdram_wr <= 1'b1;
                            state_r  <= REQ;
                        end
                    end else if (abort_i) begin
                        abort_pend_r <= 1'b1;
                    end
                end
                // Zero-size starts arrive with done_o low and spend one extra cycle here.
                DONE: begin
                    if (done_o) begin
                        done_o  <= 1'b0;
                        busy_o  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        done_o <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    busy_o       <= 1'b0;
                    done_o       <= 1'b0;
                    sdram_wr     <= 1'b0;
                    abort_pend_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
